// File: rtl/raifes_gpio_ctrl.sv
// GPIO controller on the HASTI (AHB-lite) bus: output/enable registers, atomic
// set/clear/toggle, synchronised inputs and per-pin edge interrupts on one irq.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module raifes_gpio_ctrl #(
    parameter int          GPIO_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic [GPIO_WIDTH-1:0]           gpio_o,
    output logic [GPIO_WIDTH-1:0]           gpio_oe,
    input  logic [GPIO_WIDTH-1:0]           gpio_i,
    output logic                            irq,
    input  logic [`HASTI_ADDR_WIDTH-1:0]    haddr,
    input  logic                            hwrite,
    input  logic [`HASTI_SIZE_WIDTH-1:0]    hsize,
    input  logic [`HASTI_BURST_WIDTH-1:0]   hburst,
    input  logic                            hmastlock,
    input  logic [`HASTI_PROT_WIDTH-1:0]    hprot,
    input  logic [`HASTI_TRANS_WIDTH-1:0]   htrans,
    input  logic [`HASTI_BUS_WIDTH-1:0]     hwdata,
    output logic [`HASTI_BUS_WIDTH-1:0]     hrdata,
    output logic                            hready,
    output logic [`HASTI_RESP_WIDTH-1:0]    hresp
);

    localparam logic [3:0] REG_OUT  = 4'd0;
    localparam logic [3:0] REG_OE   = 4'd1;
    localparam logic [3:0] REG_IN   = 4'd2;
    localparam logic [3:0] REG_SET  = 4'd3;
    localparam logic [3:0] REG_CLR  = 4'd4;
    localparam logic [3:0] REG_TGL  = 4'd5;
    localparam logic [3:0] REG_IE   = 4'd6;
    localparam logic [3:0] REG_POL  = 4'd7;
    localparam logic [3:0] REG_PEND = 4'd8;

    localparam int CNT_MAX = SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [GPIO_WIDTH-1:0] r_out, r_oe, r_ie, r_pol, r_pend, r_prev;
    logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid, r_write, r_irq;
    logic [3:0]            r_idx;
    logic [31:0]           r_rdata;

    logic [31:0]           w_offset;
    logic                  w_hit, w_addr_act, w_wr, w_edge_en, w_unused;
    logic [3:0]            w_idx;
    logic [GPIO_WIDTH-1:0] w_wdata, w_in, w_edge, w_clr, w_rdata;
    logic [GPIO_WIDTH-1:0] w_out_nxt, w_oe_nxt, w_ie_nxt, w_pol_nxt, w_pend_nxt;
    logic [31:0]           w_rdata32;

    // Addresses below BASE_ADDR wrap to a huge offset and so decode as a miss.
    assign w_offset   = haddr - BASE_ADDR;
    assign w_hit      = (w_offset <= 32'h20) && (w_offset[1:0] == 2'b00);
    assign w_idx      = w_offset[5:2];
    assign w_addr_act = htrans[1];
    assign w_wr       = r_valid & r_write;
    assign w_wdata    = hwdata[GPIO_WIDTH-1:0];
    assign w_in       = r_sync[SYNC_STAGES-1];
    assign w_edge_en  = (r_cnt == CNT_W'(CNT_MAX));
    assign w_unused   = ^{hsize, hburst, hmastlock, hprot, htrans[0], hwdata};

    always_comb begin
        w_edge = '0;
        if (w_edge_en)
            w_edge = (r_pol & w_in & ~r_prev) | (~r_pol & ~w_in & r_prev);
    end

    always_comb begin
        w_out_nxt = r_out;
        w_oe_nxt  = r_oe;
        w_ie_nxt  = r_ie;
        w_pol_nxt = r_pol;
        w_clr     = '0;
        if (w_wr) begin
            case (r_idx)
                REG_OUT:  w_out_nxt = w_wdata;
                REG_SET:  w_out_nxt = r_out | w_wdata;
                REG_CLR:  w_out_nxt = r_out & ~w_wdata;
                REG_TGL:  w_out_nxt = r_out ^ w_wdata;
                REG_OE:   w_oe_nxt  = w_wdata;
                REG_IE:   w_ie_nxt  = w_wdata;
                REG_POL:  w_pol_nxt = w_wdata;
                REG_PEND: w_clr     = w_wdata;
                default:  ;
            endcase
        end
    end

    // A new edge overrides a same-cycle write-1-to-clear.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;

    // Reads see the post-write value of any write in its data phase.
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_OUT:  w_rdata = w_out_nxt;
            REG_OE:   w_rdata = w_oe_nxt;
            REG_IN:   w_rdata = w_in;
            REG_IE:   w_rdata = w_ie_nxt;
            REG_POL:  w_rdata = w_pol_nxt;
            REG_PEND: w_rdata = (w_wr && r_idx == REG_PEND) ? w_pend_nxt : r_pend;
            default:  w_rdata = '0;
        endcase
    end

    always_comb begin
        w_rdata32 = '0;
        if (w_hit)
            w_rdata32[GPIO_WIDTH-1:0] = w_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_rdata <= '0;
        end else begin
            r_valid <= w_addr_act & w_hit;
            r_write <= hwrite;
            r_idx   <= w_idx;
            if (w_addr_act && !hwrite)
                r_rdata <= w_rdata32;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_oe   <= '0;
            r_ie   <= '0;
            r_pol  <= '0;
            r_pend <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
            r_irq  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= '0;
        end else begin
            r_out  <= w_out_nxt;
            r_oe   <= w_oe_nxt;
            r_ie   <= w_ie_nxt;
            r_pol  <= w_pol_nxt;
            r_pend <= w_pend_nxt;
            r_prev <= w_in;
            r_irq  <= |(r_pend & r_ie);
            if (!w_edge_en)
                r_cnt <= r_cnt + 1'b1;
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    assign gpio_o  = r_out;
    assign gpio_oe = r_oe;
    assign irq     = r_irq;
    assign hrdata  = r_rdata;
    assign hready  = 1'b1;
    assign hresp   = '0;

endmodule

// File: tb/tb_raifes_gpio_ctrl.sv
// Directed bench for raifes_gpio_ctrl: an 8-pin and a 32-pin instance share one bus.
module tb_raifes_gpio_ctrl;

    localparam logic [31:0] BASE   = 32'hC000_0100;
    localparam logic [31:0] A_OUT  = BASE + 32'h00;
    localparam logic [31:0] A_OE   = BASE + 32'h04;
    localparam logic [31:0] A_IN   = BASE + 32'h08;
    localparam logic [31:0] A_SET  = BASE + 32'h0C;
    localparam logic [31:0] A_CLR  = BASE + 32'h10;
    localparam logic [31:0] A_TGL  = BASE + 32'h14;
    localparam logic [31:0] A_IE   = BASE + 32'h18;
    localparam logic [31:0] A_POL  = BASE + 32'h1C;
    localparam logic [31:0] A_PEND = BASE + 32'h20;

    logic        clk, reset;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    logic [7:0]  gpio_i8, gpio_o8, gpio_oe8;
    logic        irq8, hready8;
    logic [31:0] hrdata8;
    logic [0:0]  hresp8;

    logic [31:0] gpio_i32, gpio_o32, gpio_oe32, hrdata32;
    logic        irq32, hready32;
    logic [0:0]  hresp32;

    int checks = 0;
    int errors = 0;

    raifes_gpio_ctrl #(.GPIO_WIDTH(8), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .gpio_i(gpio_i8), .irq(irq8),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata8), .hready(hready8), .hresp(hresp8)
    );

    raifes_gpio_ctrl #(.GPIO_WIDTH(32), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut32 (
        .clk(clk), .reset(reset),
        .gpio_o(gpio_o32), .gpio_oe(gpio_oe32), .gpio_i(gpio_i32), .irq(irq32),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata32), .hready(hready32), .hresp(hresp32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: address phase of a new transfer (if act) plus the write
    // data for the previous transfer; returns 1 time unit after the edge.
    task automatic bus(input logic act, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
        htrans = act ? 2'b10 : 2'b00;
        hwrite = wr;
        haddr  = addr;
        hwdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
        hsize = 3'd2; hburst = 3'd0; hmastlock = 1'b0; hprot = 4'd0;
        gpio_i8 = 8'hFF; gpio_i32 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_gpio_o", {24'h0, gpio_o8}, 32'h0);
        check("rst_gpio_oe", {24'h0, gpio_oe8}, 32'h0);
        check("rst_irq", {31'h0, irq8}, 32'h0);
        check("rst_hrdata", hrdata8, 32'h0);
        check("rst_hready", {31'h0, hready8}, 32'h1);
        check("rst_hresp", {31'h0, hresp8}, 32'h0);

        reset = 1'b0;
        idle(10);
        bus(1'b1, 1'b0, A_IN, 32'h0);
        check("in_after_reset", hrdata8, 32'h0000_00FF);
        bus(1'b1, 1'b0, A_PEND, 32'h0);
        check("pend_after_reset", hrdata8, 32'h0);
        check("irq_after_reset", {31'h0, irq8}, 32'h0);

        // OUT, OE, SET, CLR, TGL back-to-back, then a pipelined read of OUT
        bus(1'b1, 1'b1, A_OUT, 32'h0);
        bus(1'b1, 1'b1, A_OE,  32'h0000_00A5);
        check("seq_a5", {24'h0, gpio_o8}, 32'hA5);
        bus(1'b1, 1'b1, A_SET, 32'h0000_00FF);
        check("seq_oe", {24'h0, gpio_oe8}, 32'hFF);
        check("seq_a5_hold", {24'h0, gpio_o8}, 32'hA5);
        bus(1'b1, 1'b1, A_CLR, 32'h0000_000A);
        check("seq_af", {24'h0, gpio_o8}, 32'hAF);
        bus(1'b1, 1'b1, A_TGL, 32'h0000_0081);
        check("seq_2e", {24'h0, gpio_o8}, 32'h2E);
        bus(1'b1, 1'b0, A_OUT, 32'h0000_00F0);
        check("seq_de", {24'h0, gpio_o8}, 32'hDE);
        check("seq_read_fwd", hrdata8, 32'h0000_00DE);
        idle(1);
        bus(1'b1, 1'b0, A_OUT, 32'h0);
        check("out_read_de", hrdata8, 32'h0000_00DE);

        // write OUT then read OUT in its data phase
        bus(1'b1, 1'b1, A_OUT, 32'h0);
        check("raw_hready_a", {31'h0, hready8}, 32'h1);
        bus(1'b1, 1'b0, A_OUT, 32'h0000_003C);
        check("raw_gpio_o", {24'h0, gpio_o8}, 32'h3C);
        check("raw_hrdata", hrdata8, 32'h0000_003C);
        check("raw_hready_d", {31'h0, hready8}, 32'h1);
        idle(1);

        // write-only and unmapped locations read 0; unmapped writes are ignored
        bus(1'b1, 1'b0, A_SET, 32'h0);
        check("set_reads_0", hrdata8, 32'h0);
        bus(1'b1, 1'b0, A_OE, 32'h0);
        check("oe_read", hrdata8, 32'h0000_00FF);
        bus(1'b1, 1'b1, BASE + 32'h24, 32'h0);
        bus(1'b1, 1'b0, BASE + 32'h24, 32'h0000_00FF);
        check("unmapped_wr_ignored", {24'h0, gpio_o8}, 32'h3C);
        check("unmapped_read", hrdata8, 32'h0);
        bus(1'b1, 1'b0, BASE - 32'h4, 32'h0);
        check("below_base_read", hrdata8, 32'h0);
        check("unmapped_hresp", {31'h0, hresp8}, 32'h0);

        // rising edge on pin 0 with IE/POL bit 0 set
        bus(1'b1, 1'b1, A_IE, 32'h0);
        bus(1'b1, 1'b1, A_POL, 32'h0000_0001);
        bus(1'b1, 1'b0, A_IE, 32'h0000_0001);
        check("ie_read", hrdata8, 32'h0000_0001);
        bus(1'b1, 1'b0, A_POL, 32'h0);
        check("pol_read", hrdata8, 32'h0000_0001);
        gpio_i8 = 8'hFE;
        idle(5);
        bus(1'b1, 1'b0, A_PEND, 32'h0);
        check("fall_ignored_pol1", hrdata8, 32'h0);
        gpio_i8 = 8'hFF;
        idle(3);
        check("irq_not_yet", {31'h0, irq8}, 32'h0);
        bus(1'b1, 1'b0, A_PEND, 32'h0);
        check("irq_rise", {31'h0, irq8}, 32'h1);
        check("pend_rise", hrdata8, 32'h0000_0001);
        bus(1'b1, 1'b1, A_PEND, 32'h0);
        bus(1'b0, 1'b0, 32'h0, 32'h0000_0001);
        check("irq_hold_after_w1c", {31'h0, irq8}, 32'h1);
        idle(1);
        check("irq_clear", {31'h0, irq8}, 32'h0);

        // falling edge on pin 3 collides with W1C of PEND[3]: set wins
        gpio_i8 = 8'hF7;
        idle(1);
        bus(1'b1, 1'b1, A_PEND, 32'h0);
        bus(1'b0, 1'b0, 32'h0, 32'h0000_0008);
        bus(1'b1, 1'b0, A_PEND, 32'h0);
        check("set_beats_w1c", hrdata8, 32'h0000_0008);
        check("irq_masked", {31'h0, irq8}, 32'h0);
        bus(1'b1, 1'b1, A_PEND, 32'h0);
        bus(1'b1, 1'b0, A_PEND, 32'h0000_0008);
        check("w1c_fwd_read", hrdata8, 32'h0);

        // 32-pin instance: full-width OUT, unmapped read
        bus(1'b1, 1'b1, A_OUT, 32'h0);
        bus(1'b1, 1'b0, BASE + 32'h40, 32'hDEAD_BEEF);
        check("w32_gpio_o", gpio_o32, 32'hDEAD_BEEF);
        check("w32_unmapped_read", hrdata32, 32'h0);
        check("w32_hresp", {31'h0, hresp32}, 32'h0);
        check("w8_truncated", {24'h0, gpio_o8}, 32'hEF);

        // reset during a write data phase discards the write
        bus(1'b1, 1'b1, A_OUT, 32'h0);
        htrans = 2'b00; hwdata = 32'h0000_0055; reset = 1'b1;
        #2;
        check("midrst_gpio_o", {24'h0, gpio_o8}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_no_write", {24'h0, gpio_o8}, 32'h0);
        check("midrst_no_write32", gpio_o32, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
